// File: rtl/esm_fetch_decode.sv
// Generic synchronous FIFO followed by the ESM fetch/decode issue stage.
// Latency: a word pushed at edge N can be popped at edge N+1 at the earliest.
// Backpressure: the caller must only push when count < DEPTH and only pop when count > 0.
module esm_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
endmodule

// Buffers RV32I words and issues one registered instruction per cycle with ALUSrc/RegWrite.
// Latency: word accepted at edge N is issued after edge N+1 at the earliest; NOP when empty.
// Backpressure: in_ready drops when the FIFO is full or in a flush cycle; stall holds the issue regs.
module esm_fetch_decode #(
    parameter int                   Instr_word_size = 32,
    parameter int                   fd              = 4,
    parameter logic [Instr_word_size-1:0] NOP       = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [Instr_word_size-1:0] in_instr,
    output logic                       in_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic [Instr_word_size-1:0] Instr_out,
    output logic                       ALUSrc,
    output logic                       RegWrite,
    output logic                       out_valid,
    output logic                       illegal,
    output logic [$clog2(fd):0]        fifo_count
);
    localparam int CW = $clog2(fd) + 1;
    localparam logic [CW-1:0] FD_CNT = CW'(fd);

    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    logic [Instr_word_size-1:0] head;
    logic                       dec_alu;
    logic                       dec_rw;
    logic                       dec_ill;

    assign in_ready   = (fifo_count < FD_CNT) && !flush;
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !stall && !flush && !fifo_empty;

    esm_fifo #(.W(Instr_word_size), .DEPTH(fd)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (push),
        .push_dat (in_instr),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    always_comb begin
        dec_alu = 1'b0;
        dec_rw  = 1'b0;
        dec_ill = 1'b0;
        case (head[6:0])
            7'b0110011: begin dec_alu = 1'b0; dec_rw = 1'b1; end
            7'b0010011: begin dec_alu = 1'b1; dec_rw = 1'b1; end
            7'b0000011: begin dec_alu = 1'b1; dec_rw = 1'b1; end
            7'b0100011: begin dec_alu = 1'b1; dec_rw = 1'b0; end
            7'b1100011: begin dec_alu = 1'b0; dec_rw = 1'b0; end
            7'b1101111: begin dec_alu = 1'b1; dec_rw = 1'b1; end
            7'b1100111: begin dec_alu = 1'b1; dec_rw = 1'b1; end
            7'b0110111: begin dec_alu = 1'b1; dec_rw = 1'b1; end
            7'b0010111: begin dec_alu = 1'b1; dec_rw = 1'b1; end
            default:    dec_ill = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded.
        if (head[11:7] == 5'd0) dec_rw = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Instr_out <= NOP;
            ALUSrc    <= 1'b0;
            RegWrite  <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush || (!stall && fifo_empty)) begin
            Instr_out <= NOP;
            ALUSrc    <= 1'b0;
            RegWrite  <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (!stall) begin
            Instr_out <= head;
            ALUSrc    <= dec_alu;
            RegWrite  <= dec_rw;
            out_valid <= 1'b1;
            illegal   <= dec_ill;
        end
    end
endmodule

// File: tb/tb_esm_fetch_decode.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_esm_fetch_decode;
    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] Instr_out;
    logic        ALUSrc, RegWrite, out_valid, illegal;
    logic [2:0]  fifo_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q[$];
    logic [31:0] m_instr = NOP_W;
    logic        m_alu = 0, m_rw = 0, m_vld = 0, m_ill = 0;

    esm_fetch_decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .stall(stall), .flush(flush), .Instr_out(Instr_out),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .out_valid(out_valid),
        .illegal(illegal), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic ref_dec(input logic [31:0] w, output logic alu, output logic rw, output logic ill);
        alu = 0; rw = 0; ill = 0;
        case (w[6:0])
            7'b0110011:                                              rw = 1;
            7'b0100011:                                   alu = 1;
            7'b1100011: ;
            7'b0010011, 7'b0000011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: begin alu = 1; rw = 1; end
            default: ill = 1;
        endcase
        if (w[11:7] == 0) rw = 0;
    endtask

    task automatic bubble();
        m_instr = NOP_W; m_alu = 0; m_rw = 0; m_vld = 0; m_ill = 0;
    endtask

    // One clock edge; the reference model advances from the pre-edge inputs.
    task automatic tick();
        logic        p, f, s;
        logic [31:0] pw, w;
        f  = flush;
        s  = stall;
        p  = in_valid && (q.size() < 4) && !f;
        pw = in_instr;
        @(posedge clk);
        if (f) begin
            q.delete();
            bubble();
        end else begin
            if (!s) begin
                if (q.size() > 0) begin
                    w = q.pop_front();
                    m_instr = w;
                    ref_dec(w, m_alu, m_rw, m_ill);
                    m_vld = 1;
                end else bubble();
            end
            if (p) q.push_back(pw);
        end
        #1;
    endtask

    task automatic test_reset();
        stall = 1; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_instr = 32'h00000033 + (i << 7);
            tick();
        end
        #2 rst = 0;
        #1;
        q.delete(); bubble();
        vectors++;
        if (Instr_out !== NOP_W || out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: instr=%h vld=%b cnt=%0d, want %h 0 0", Instr_out, out_valid, fifo_count, NOP_W);
        end
        in_valid = 0; stall = 0;
        rst = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1; in_instr = 32'h002081B3;
        tick();
        in_valid = 0;
        vectors++;
        if (fifo_count !== 3'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_n: cnt=%0d vld=%b want 1 0", fifo_count, out_valid);
        end
        tick();
        vectors++;
        if ({Instr_out, ALUSrc, RegWrite, out_valid, illegal} !== {32'h002081B3, 4'b0110}) begin
            miscompares++;
            $display("FAIL single_n1: got %h %b%b%b%b want 002081b3 0110", Instr_out, ALUSrc, RegWrite, out_valid, illegal);
        end
        tick();
        vectors++;
        if (Instr_out !== NOP_W || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_n2: got %h vld=%b want bubble", Instr_out, out_valid);
        end
    endtask

    task automatic test_decode();
        logic [31:0] dw [3];
        logic [3:0]  ex [3];
        dw[0] = 32'h00A12023; ex[0] = 4'b1010;
        dw[1] = 32'h00500013; ex[1] = 4'b1010;
        dw[2] = 32'hFFFFFFFF; ex[2] = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = dw[i];
            tick();
            in_valid = 0;
            tick();
            vectors++;
            if ({Instr_out, ALUSrc, RegWrite, out_valid, illegal} !== {dw[i], ex[i]}) begin
                miscompares++;
                $display("FAIL decode_%0d: got %h %b%b%b%b want %h %b", i, Instr_out, ALUSrc, RegWrite, out_valid, illegal, dw[i], ex[i]);
            end
        end
    endtask

    task automatic test_full_wrap();
        int          k = 0;
        logic        acc;
        logic [31:0] got[$];
        stall = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'h00100093 + (k << 20);
            tick();
            k++;
        end
        vectors++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full: cnt=%0d in_ready=%b want 4 0", fifo_count, in_ready);
        end
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            if (k < 12) begin
                in_valid = 1; in_instr = 32'h00100093 + (k << 20);
            end else in_valid = 0;
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            if (out_valid) got.push_back(Instr_out);
        end
        vectors++;
        if (got.size() != 12) begin
            miscompares++;
            $display("FAIL wrap_count: issued %0d want 12", got.size());
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 32'h00100093 + (i << 20)) begin
                miscompares++;
                $display("FAIL wrap_order_%0d: got %h want %h", i, got[i], 32'h00100093 + (i << 20));
            end
        end
    endtask

    task automatic test_stall_hold();
        in_valid = 1; in_instr = 32'h0000A283;
        tick();
        in_valid = 0;
        tick();
        stall = 1; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_instr = 32'h00000033 + ((i + 1) << 7);
            tick();
            vectors++;
            if ({Instr_out, ALUSrc, RegWrite, out_valid} !== {32'h0000A283, 3'b111} || fifo_count !== 3'(i + 1)) begin
                miscompares++;
                $display("FAIL stall_%0d: got %h %b%b%b cnt=%0d want 0000a283 111 cnt=%0d", i, Instr_out, ALUSrc, RegWrite, out_valid, fifo_count, i + 1);
            end
        end
    endtask

    task automatic test_flush();
        flush = 1; in_valid = 1; in_instr = 32'h00C00513;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        vectors++;
        if (fifo_count !== 3'd0 || Instr_out !== NOP_W || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_edge: cnt=%0d instr=%h vld=%b want 0 %h 0", fifo_count, Instr_out, out_valid, NOP_W);
        end
        flush = 0; stall = 0; in_valid = 0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_drop: vld=%b cnt=%0d want 0 0", out_valid, fifo_count);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b1111011;
        for (int c = 0; c < 400; c++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
            in_instr = w;
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            #1;
            vectors++;
            if (in_ready !== ((q.size() < 4) && !flush)) begin
                miscompares++;
                $display("FAIL rand_ready_%0d: got %b want %b", c, in_ready, (q.size() < 4) && !flush);
            end
            tick();
            vectors++;
            if ({Instr_out, ALUSrc, RegWrite, out_valid, illegal, fifo_count} !==
                {m_instr, m_alu, m_rw, m_vld, m_ill, 3'(q.size())}) begin
                miscompares++;
                $display("FAIL rand_out_%0d: got %h %b%b%b%b cnt=%0d want %h %b%b%b%b cnt=%0d", c,
                         Instr_out, ALUSrc, RegWrite, out_valid, illegal, fifo_count,
                         m_instr, m_alu, m_rw, m_vld, m_ill, q.size());
            end
        end
        in_valid = 0; stall = 0; flush = 0;
    endtask

    initial begin
        #2 rst = 1;
        #1;
        test_reset();
        test_single();
        test_decode();
        test_full_wrap();
        test_stall_hold();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
